// File: rtl/conv_window_3x3_if.sv
// conv_window_3x3_if: pixel-in / window-out signal bundle for the 3x3 window generator.
interface conv_window_3x3_if #(
    parameter int WIDTH = 4
) ();
    logic               in_valid;
    logic [WIDTH-1:0]   in_pix;
    logic               win_valid;
    logic [9*WIDTH-1:0] win;
    logic               frame_done;
    modport master (output in_valid, in_pix, input win_valid, win, frame_done);
    modport slave  (input in_valid, in_pix, output win_valid, win, frame_done);
endinterface

// File: rtl/conv_window_3x3.sv
// conv_window_3x3: streaming 3x3 valid-window generator built from two row delay lines.
module conv_window_3x3 #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int WIDTH = 4
) (
    input logic clk,
    input logic rst,
    conv_window_3x3_if.slave i_bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic [CW-1:0]             r_col;
    logic [RW-1:0]             r_row;
    logic [IMG_W*WIDTH-1:0]    r_lb1, r_lb2;
    logic [2:0][2*WIDTH-1:0]   r_hist;
    logic [2:0][WIDTH-1:0]     w_new;
    logic [2:0][3*WIDTH-1:0]   w_win;
    logic                      w_last_col, w_last_row, w_emit;
    assign w_last_col = r_col == CW'(IMG_W - 1);
    assign w_last_row = r_row == RW'(IMG_H - 1);
    assign w_emit     = i_bus.in_valid && r_row >= RW'(2) && r_col >= CW'(2);
    assign w_new      = {i_bus.in_pix, r_lb1[IMG_W*WIDTH-1 -: WIDTH], r_lb2[IMG_W*WIDTH-1 -: WIDTH]};
    // r_hist holds columns col-2 (upper half) and col-1 (lower half) of each window row
    always_comb begin
        for (int k = 0; k < 3; k++)
            w_win[k] = {w_new[k], r_hist[k][WIDTH-1:0], r_hist[k][2*WIDTH-1:WIDTH]};
    end
    always_ff @(posedge clk) begin
        if (i_bus.in_valid) begin
            r_lb1 <= {r_lb1[(IMG_W-1)*WIDTH-1:0], i_bus.in_pix};
            r_lb2 <= {r_lb2[(IMG_W-1)*WIDTH-1:0], r_lb1[IMG_W*WIDTH-1 -: WIDTH]};
            for (int k = 0; k < 3; k++)
                r_hist[k] <= {r_hist[k][WIDTH-1:0], w_new[k]};
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col            <= '0;
            r_row            <= '0;
            i_bus.win_valid  <= 1'b0;
            i_bus.frame_done <= 1'b0;
            i_bus.win        <= '0;
        end else begin
            if (i_bus.in_valid) begin
                r_col <= w_last_col ? '0 : r_col + CW'(1);
                r_row <= w_last_col ? (w_last_row ? '0 : r_row + RW'(1)) : r_row;
            end
            i_bus.win_valid  <= w_emit;
            i_bus.frame_done <= w_emit && w_last_col && w_last_row;
            if (w_emit)
                i_bus.win <= w_win;
        end
    end
endmodule

// File: tb/tb_conv_window_3x3.sv
// tb_conv_window_3x3: directed vector tables on a 4x4 instance plus a 32x32 reference-model run.
module tb_conv_window_3x3;
    typedef struct {
        logic        v;
        logic [3:0]  p;
        logic        ewv;
        logic        efd;
        logic [35:0] ewin;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t q[$];
    logic [35:0] held;
    logic [3:0]  img [32][32];

    always #5 clk = ~clk;

    conv_window_3x3_if #(.WIDTH(4)) bus4 ();
    conv_window_3x3_if #(.WIDTH(4)) bus32 ();

    conv_window_3x3 #(.IMG_W(4), .IMG_H(4), .WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_bus(bus4.slave)
    );
    conv_window_3x3 u_dut32 (
        .clk(clk), .rst(rst), .i_bus(bus32.slave)
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] p9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
        return {4'(t8), 4'(t7), 4'(t6), 4'(t5), 4'(t4), 4'(t3), 4'(t2), 4'(t1), 4'(t0)};
    endfunction

    // one 4x4 frame; windows appear at pixels 10, 11, 14, 15 and win holds between them
    task automatic push_frame(input bit inv, input bit gap, input logic [35:0] w0, w1, w2, w3);
        vec_t e;
        for (int k = 0; k < 16; k++) begin
            e.v   = 1'b1;
            e.p   = 4'(inv ? 15 - k : k);
            e.ewv = (k / 4 >= 2) && (k % 4 >= 2);
            e.efd = (k == 15);
            if (e.ewv) held = (k == 10) ? w0 : (k == 11) ? w1 : (k == 14) ? w2 : w3;
            e.ewin = held;
            q.push_back(e);
            if (gap) begin
                e.v   = 1'b0;
                e.ewv = 1'b0;
                e.efd = 1'b0;
                q.push_back(e);
                q.push_back(e);
            end
        end
    endtask

    task automatic run_q(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus4.in_valid = q[i].v;
            bus4.in_pix   = q[i].p;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].win_valid", tag, i), 36'(bus4.win_valid), 36'(q[i].ewv));
            chk($sformatf("%s[%0d].frame_done", tag, i), 36'(bus4.frame_done), 36'(q[i].efd));
            chk($sformatf("%s[%0d].win", tag, i), bus4.win, q[i].ewin);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus4.in_valid  = 1'b0;
        bus32.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        held = '0;
        q.delete();
    endtask

    logic [35:0] a0, a1, a2, a3, b0, b1, b2, b3;

    initial begin
        int nwin, nfd;
        logic [35:0] exp, held32;
        bus4.in_valid  = 1'b0;
        bus4.in_pix    = '0;
        bus32.in_valid = 1'b0;
        bus32.in_pix   = '0;
        a0 = p9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        a1 = p9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        a2 = p9(4, 5, 6, 8, 9, 10, 12, 13, 14);
        a3 = p9(5, 6, 7, 9, 10, 11, 13, 14, 15);
        b0 = p9(15, 14, 13, 11, 10, 9, 7, 6, 5);
        b1 = p9(14, 13, 12, 10, 9, 8, 6, 5, 4);
        b2 = p9(11, 10, 9, 7, 6, 5, 3, 2, 1);
        b3 = p9(10, 9, 8, 6, 5, 4, 2, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.win_valid4", 36'(bus4.win_valid), 36'(0));
        chk("rst.frame_done4", 36'(bus4.frame_done), 36'(0));
        chk("rst.win4", bus4.win, 36'(0));
        chk("rst.win_valid32", 36'(bus32.win_valid), 36'(0));
        chk("rst.frame_done32", 36'(bus32.frame_done), 36'(0));
        chk("rst.win32", bus32.win, 36'(0));

        do_reset();
        push_frame(1'b0, 1'b0, a0, a1, a2, a3);
        run_q("cont", q.size());

        do_reset();
        push_frame(1'b0, 1'b1, a0, a1, a2, a3);
        run_q("gap", q.size());

        do_reset();
        push_frame(1'b0, 1'b0, a0, a1, a2, a3);
        push_frame(1'b1, 1'b0, b0, b1, b2, b3);
        run_q("b2b", q.size());

        // reset lands while the second window of the frame is on the outputs
        do_reset();
        push_frame(1'b0, 1'b0, a0, a1, a2, a3);
        run_q("pre", 12);
        bus4.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst.win_valid", 36'(bus4.win_valid), 36'(0));
        chk("midrst.frame_done", 36'(bus4.frame_done), 36'(0));
        chk("midrst.win", bus4.win, 36'(0));
        @(negedge clk);
        rst = 1'b0;
        held = '0;
        q.delete();
        push_frame(1'b0, 1'b0, a0, a1, a2, a3);
        run_q("post", q.size());

        do_reset();
        nwin = 0;
        nfd = 0;
        held32 = '0;
        for (int k = 0; k < 1024; k++) begin
            int r, c;
            r = k / 32;
            c = k % 32;
            @(negedge clk);
            img[r][c] = 4'($urandom_range(0, 15));
            bus32.in_valid = 1'b1;
            bus32.in_pix   = img[r][c];
            @(posedge clk);
            #1;
            if (bus32.win_valid) nwin++;
            if (bus32.frame_done) nfd++;
            chk($sformatf("big[%0d].win_valid", k), 36'(bus32.win_valid), 36'(r >= 2 && c >= 2));
            chk($sformatf("big[%0d].frame_done", k), 36'(bus32.frame_done), 36'(r == 31 && c == 31));
            if (r >= 2 && c >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp[4*(3*i+j) +: 4] = img[r-2+i][c-2+j];
                held32 = exp;
            end
            chk($sformatf("big[%0d].win", k), bus32.win, held32);
        end
        chk("big.window_count", 36'(nwin), 36'(900));
        chk("big.frame_done_count", 36'(nfd), 36'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
